membus_uart_master: RTL and testbench
=====================================

Name: membus_uart_master

Overview:
- Bus-initiator bridge. It takes a byte-stream command protocol from a UART-style RX port and turns each command into single-word transactions on the native valid/ready memory bus, the same bus a picorv32 core drives.
- It returns acknowledgements and read data as bytes on a TX stream.
- It sits beside or in place of the CPU as a second bus master, e.g. for debug peek/poke or for loading programs into RAM.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum number of cycles mem_valid is held waiting for mem_ready before the transaction is aborted. 0 disables the timeout.
- NAK_BYTE, 8'h15: response byte for failure or an unknown opcode.
- ACK_BYTE, 8'h06: response byte for a successful write or clear.

Ports:
- clk  input  1  clock; all logic on the rising edge
- resetn  input  1  synchronous, active-low reset
- rx_data  input  8  command byte in
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  block accepts a byte this cycle
- tx_data  output  8  response byte out
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts tx_data this cycle
- mem_valid  output  1  bus request
- mem_instr  output  1  tied 0
- mem_addr  output  32  word address; bits [1:0] always 0
- mem_wdata  output  32  write data
- mem_wstrb  output  4  4'hF for a write, 4'h0 for a read
- mem_ready  input  1  responder completes the transfer
- mem_rdata  input  32  read data, valid when mem_ready=1
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky; set on timeout or unknown opcode

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; byte/timeout counters=0; rx_ready=0, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, err=0.
- Reset overrides everything, including mid-transaction: mem_valid is 0 after the reset edge.
- All outputs are registered except rx_ready, which is 1 exactly in IDLE, ADDR and DATA.
- A byte is accepted on a cycle with rx_valid&&rx_ready. A TX byte is consumed on a cycle with tx_valid&&tx_ready. tx_data is stable while tx_valid=1.
- Opcodes (first byte, accepted in IDLE):
  - 0x57 'W': 4 address bytes then 4 data bytes.
  - 0x52 'R': 4 address bytes.
  - 0x43 'C': clear err; respond ACK.
  - Any other byte: set err, respond NAK.
- Multi-byte fields are LSB-first. Address byte 0 bits [1:0] are ignored, so mem_addr[1:0]=0.
- States:
  - IDLE -> ADDR on 'W'/'R'; -> RESP on 'C' or an unknown opcode.
  - ADDR: 4 accepted bytes, then -> DATA (W) or -> BUS (R).
  - DATA: 4 accepted bytes, then -> BUS.
  - BUS: mem_valid=1 from the cycle after entry. mem_addr/mem_wdata/mem_wstrb are stable while mem_valid=1.
    - On the first edge where mem_valid&&mem_ready: capture mem_rdata (R), mem_valid<=0, -> RESP.
    - A mem_ready seen while mem_valid=0 is ignored.
  - Timeout: a counter starts at 0 on BUS entry and increments every cycle with mem_valid=1 and mem_ready=0. When it reaches TIMEOUT_CYCLES-1 with mem_ready still 0: mem_valid<=0, err<=1, response=NAK, -> RESP.
  - If mem_ready and the timeout condition hit on the same edge, mem_ready wins (success).
  - RESP: sends the queued bytes, then -> IDLE.
    - W success: ACK.
    - R success: 4 bytes of the captured rdata, LSB-first.
    - Fail/unknown: NAK.
    - Each byte is held until tx_ready. The next byte is presented the cycle after a handshake; no byte is ever dropped or duplicated.
- Only one bus transaction is outstanding; mem_valid never re-asserts without a return to IDLE.
- RX bytes arriving in BUS/RESP are not accepted (rx_ready=0, backpressure).
- Minimum latency, last command byte accepted to mem_valid=1: 2 cycles. Zero-wait responder, mem_ready to tx_valid: 1 cycle.

Test Plan:
- Write: RX 57 00 40 00 00 EF BE AD DE, responder ready after 3 cycles -> one mem_valid pulse, addr=0x00004000, wdata=0xDEADBEEF, wstrb=F, held stable until ready; TX 06; busy returns to 0.
- Read: RX 52 07 40 00 00, responder returns 0x12345678 with 0 wait -> addr=0x00004004 (low bits masked), wstrb=0; TX 78 56 34 12 in order, with tx_ready toggled randomly and no loss or duplication.
- Timeout: TIMEOUT_CYCLES=16, RX read to an address whose mem_ready is never asserted -> mem_valid drops after exactly 16 cycles high; err=1; TX 15. Then RX 43 -> TX 06, err=0.
- Unknown opcode 0xAA -> TX 15, err=1, no mem_valid. A following valid write completes normally.
- Reset mid-BUS (resetn=0 while mem_valid=1, mem_ready=0) -> next edge mem_valid=0, tx_valid=0, busy=0. A new read after reset completes correctly.
- mem_ready and the timeout limit on the same cycle -> success path: TX data bytes, err unchanged.

Source files
------------

// File: rtl/membus_uart_master.sv
// Byte-stream command bridge: turns 'W'/'R'/'C' commands from an RX byte stream into
// single-word valid/ready memory bus transactions and returns ACK/NAK/read data on TX.
module membus_uart_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic        r_is_write;
    logic [31:0] r_to_cnt;
    logic [23:0] r_resp;
    logic [1:0]  r_resp_left;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_busy;
    logic        r_err;
    logic        w_rx_fire;

    // rx_ready is the only combinational output; it is held low while reset is asserted
    assign rx_ready  = resetn && ((r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA));
    assign w_rx_fire = rx_valid && rx_ready;

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign mem_valid = r_mem_valid;
    assign mem_instr = 1'b0;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign busy      = r_busy;
    assign err       = r_err;

    // Command parser, bus sequencer and response serializer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_is_write  <= 1'b0;
            r_to_cnt    <= 32'd0;
            r_resp      <= 24'd0;
            r_resp_left <= 2'd0;
            r_tx_data   <= 8'd0;
            r_tx_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_byte_cnt <= 2'd0;
                        r_busy     <= 1'b1;
                        case (rx_data)
                            8'h57: begin
                                r_is_write <= 1'b1;
                                r_state    <= S_ADDR;
                            end
                            8'h52: begin
                                r_is_write <= 1'b0;
                                r_state    <= S_ADDR;
                            end
                            8'h43: begin
                                r_err       <= 1'b0;
                                r_tx_data   <= ACK_BYTE;
                                r_tx_valid  <= 1'b1;
                                r_resp_left <= 2'd0;
                                r_state     <= S_RESP;
                            end
                            default: begin
                                r_err       <= 1'b1;
                                r_tx_data   <= NAK_BYTE;
                                r_tx_valid  <= 1'b1;
                                r_resp_left <= 2'd0;
                                r_state     <= S_RESP;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        // Address lanes fill LSB-first; lane 0 drops the byte-offset bits
                        r_mem_addr[{r_byte_cnt, 3'b000} +: 8] <=
                            (r_byte_cnt == 2'd0) ? {rx_data[7:2], 2'b00} : rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_DATA;
                            end else begin
                                r_mem_wstrb <= 4'h0;
                                r_to_cnt    <= 32'd0;
                                r_state     <= S_BUS;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_mem_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_wstrb <= 4'hF;
                            r_to_cnt    <= 32'd0;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (!r_mem_valid) begin
                        r_mem_valid <= 1'b1;
                    end else if (mem_ready) begin
                        // A ready on the timeout edge still counts as success
                        r_mem_valid <= 1'b0;
                        r_tx_valid  <= 1'b1;
                        r_state     <= S_RESP;
                        if (r_is_write) begin
                            r_tx_data   <= ACK_BYTE;
                            r_resp_left <= 2'd0;
                        end else begin
                            r_tx_data   <= mem_rdata[7:0];
                            r_resp      <= mem_rdata[31:8];
                            r_resp_left <= 2'd3;
                        end
                    end else if ((TIMEOUT_CYCLES != 32'd0) && (r_to_cnt == TO_LAST)) begin
                        r_mem_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_tx_data   <= NAK_BYTE;
                        r_tx_valid  <= 1'b1;
                        r_resp_left <= 2'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end
                S_RESP: begin
                    if (r_tx_valid && tx_ready) begin
                        if (r_resp_left == 2'd0) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tx_data   <= r_resp[7:0];
                            r_resp      <= {8'h00, r_resp[23:8]};
                            r_resp_left <= r_resp_left - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_uart_master.sv
// Randomized scoreboard bench for membus_uart_master: commands push expected bus
// transactions and TX bytes; independent monitors pop and compare.
module tb_membus_uart_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;
    logic        err;

    membus_uart_master #(.TIMEOUT_CYCLES(T), .NAK_BYTE(8'h15), .ACK_BYTE(8'h06)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          hi;
    } bus_t;

    bus_t        busq[$];
    logic [7:0]  txq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_err = 1'b0;
    int          resp_wait = 0;
    logic [31:0] resp_rdata = 32'd0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", nm);
    endfunction

    // Reference rules: the bus gives up after T cycles unless ready comes within them
    function automatic bit timed_out(int w);
        return (w < 0) || (w >= T);
    endfunction

    function automatic int hi_of(int w);
        return timed_out(w) ? T : w + 1;
    endfunction

    // Responder: asserts ready after resp_wait high cycles (never if negative); noise while idle
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_valid) begin
            mem_ready = (resp_wait >= 0) && (vcnt >= resp_wait);
            mem_rdata = mem_ready ? resp_rdata : $urandom;
            vcnt++;
        end else begin
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            vcnt = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        tx_ready = ($urandom_range(0, 3) != 0);
    end

    // TX monitor: ordered byte check and hold-while-stalled check
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    always @(negedge clk) begin : tx_mon
        logic [7:0] e;
        if (resetn) begin
            if (pv && !pr) begin
                chk("tx_hold_valid", tx_valid, 1);
                chk("tx_hold_data", tx_data, pd);
            end
            if (tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    e = txq.pop_front();
                    chk("tx_byte", tx_data, e);
                end
            end
        end
        pv = tx_valid && resetn;
        pr = tx_ready;
        pd = tx_data;
    end

    // Bus monitor: one expected transaction per mem_valid pulse, stability and pulse length
    logic        pm = 1'b0;
    int          hi = 0;
    bus_t        cur;
    logic        cur_ok = 1'b0;
    logic [31:0] sa = 32'd0;
    logic [31:0] sw = 32'd0;
    logic [3:0]  ss = 4'd0;
    always @(negedge clk) begin
        if (mem_valid) begin
            if (!pm) begin
                hi = 0;
                if (busq.size() == 0) begin
                    cur_ok = 1'b0;
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", mem_addr);
                end else begin
                    cur = busq.pop_front();
                    cur_ok = 1'b1;
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_wstrb", mem_wstrb, cur.wstrb);
                    chk("mem_instr", mem_instr, 0);
                    if (cur.wstrb == 4'hF) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                chk("addr_stable", mem_addr, sa);
                chk("wdata_stable", mem_wdata, sw);
                chk("wstrb_stable", mem_wstrb, ss);
            end
            sa = mem_addr;
            sw = mem_wdata;
            ss = mem_wstrb;
            hi++;
        end else if (pm && cur_ok && (cur.hi >= 0)) begin
            chk("valid_cycles", hi, cur.hi);
        end
        pm = mem_valid;
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (k == 500) fail_now("rx_accept");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 3));
    endtask

    task automatic send_word(logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ((txq.size() == 0) && (busq.size() == 0) && !busy) break;
        end
        if (k == 3000) fail_now("cmd_done");
        @(posedge clk);
        #1;
        chk("err", err, model_err);
        chk("rx_ready_idle", rx_ready, 1);
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d, int w);
        bus_t t;
        t.addr = {a[31:2], 2'b00}; t.wdata = d; t.wstrb = 4'hF; t.hi = hi_of(w);
        busq.push_back(t);
        if (timed_out(w)) begin
            txq.push_back(8'h15);
            model_err = 1'b1;
        end else begin
            txq.push_back(8'h06);
        end
        resp_wait = w;
        send_byte(8'h57);
        send_word(a);
        send_word(d);
        wait_done();
    endtask

    task automatic do_read(logic [31:0] a, logic [31:0] rd, int w);
        bus_t t;
        t.addr = {a[31:2], 2'b00}; t.wdata = 32'd0; t.wstrb = 4'h0; t.hi = hi_of(w);
        busq.push_back(t);
        if (timed_out(w)) begin
            txq.push_back(8'h15);
            model_err = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) txq.push_back(rd[8*i +: 8]);
        end
        resp_wait  = w;
        resp_rdata = rd;
        send_byte(8'h52);
        send_word(a);
        wait_done();
    endtask

    task automatic do_clear();
        txq.push_back(8'h06);
        model_err = 1'b0;
        send_byte(8'h43);
        wait_done();
    endtask

    task automatic do_unknown(logic [7:0] op);
        txq.push_back(8'h15);
        model_err = 1'b1;
        send_byte(op);
        wait_done();
    endtask

    task automatic reset_mid_bus();
        bus_t t;
        int k;
        t.addr = 32'h0000_2000; t.wdata = 32'd0; t.wstrb = 4'h0; t.hi = -1;
        busq.push_back(t);
        resp_wait = -1;
        send_byte(8'h52);
        send_word(32'h0000_2000);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        if (k == 100) fail_now("mem_valid_rise");
        @(posedge clk);
        #1;
        cyc(3);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        model_err = 1'b0;
        resetn = 1'b1;
        cyc(1);
    endtask

    int waits [9] = '{0, 1, 2, 5, 14, 15, 16, 20, -1};

    initial begin
        logic [7:0] op;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_ready", rx_ready, 0);
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_mem_valid", mem_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_mem_wstrb", mem_wstrb, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        resetn = 1'b1;
        cyc(2);

        do_write(32'h0000_4000, 32'hDEAD_BEEF, 3);
        do_read(32'h0000_4007, 32'h1234_5678, 0);
        do_read(32'h0000_0100, 32'h0BAD_0BAD, -1);
        do_clear();
        do_unknown(8'hAA);
        do_write(32'h0000_0010, 32'hA5A5_5A5A, 1);
        reset_mid_bus();
        do_read(32'h0000_2000, 32'h8765_4321, 2);
        do_unknown(8'hFF);
        do_read(32'h0000_3000, 32'hCAFE_F00D, T - 1);
        do_clear();

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_write($urandom, $urandom, waits[$urandom_range(0, 8)]);
                4, 5, 6, 7: do_read($urandom, $urandom, waits[$urandom_range(0, 8)]);
                8: do_clear();
                default: begin
                    op = 8'($urandom);
                    if ((op == 8'h57) || (op == 8'h52) || (op == 8'h43)) op = 8'hAA;
                    do_unknown(op);
                end
            endcase
        end

        cyc(5);
        chk("txq_empty", txq.size(), 0);
        chk("busq_empty", busq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
